// File: rtl/wide_adder_sched_pkg.sv
// Shared types and constants for the shared-adder sequencer.
package wide_adder_sched_pkg;

  localparam int ADDER_W = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } sched_state_t;

endpackage

// File: rtl/wide_adder_sched_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr wins.
module rr_arbiter #(
  parameter int N = 2,
  localparam int IW = $clog2(N) + 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] gnt_idx,
  output logic          any
);

  logic [31:0] cand;

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    any     = 1'b0;
    cand    = '0;
    for (int off = 0; off < N; off++) begin
      cand = (32'(ptr) + 32'(off)) % 32'(N);
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        gnt_idx   = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/wide_adder_sched.sv
// Time-shares one 16-bit adder among NUM_REQ requesters, running OP_WIDTH-bit
// add/sub as back-to-back 16-bit beats with the carry chained through a register.
module wide_adder_sched
  import wide_adder_sched_pkg::*;
#(
  parameter int NUM_REQ  = 2,
  parameter int OP_WIDTH = 32
) (
  input  logic                        cp2,
  input  logic                        ireset,
  input  logic [NUM_REQ-1:0]          req_valid,
  output logic [NUM_REQ-1:0]          req_ready,
  input  logic [NUM_REQ*OP_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*OP_WIDTH-1:0] req_b,
  input  logic [NUM_REQ-1:0]          req_sub,
  input  logic [NUM_REQ-1:0]          req_ci,
  output logic                        rsp_valid,
  input  logic                        rsp_ready,
  output logic [$clog2(NUM_REQ):0]    rsp_id,
  output logic [OP_WIDTH-1:0]         rsp_sum,
  output logic                        rsp_co,
  output logic                        rsp_z,
  output logic [ADDER_W-1:0]          add_a,
  output logic [ADDER_W-1:0]          add_b,
  output logic                        add_ci,
  input  logic [ADDER_W-1:0]          add_s,
  input  logic                        add_co
);

  localparam int NBEAT  = OP_WIDTH / ADDER_W;
  localparam int ID_W   = $clog2(NUM_REQ) + 1;
  localparam int BEAT_W = (NBEAT > 1) ? $clog2(NBEAT) : 1;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(NBEAT - 1);
  localparam logic [ID_W-1:0]   LAST_ID   = ID_W'(NUM_REQ - 1);

  sched_state_t          state;
  logic [ID_W-1:0]       rr_ptr;
  logic [ID_W-1:0]       gnt_idx;
  logic [NUM_REQ-1:0]    gnt;
  logic                  gnt_any;
  logic [BEAT_W-1:0]     beat;
  logic                  carry;
  logic [OP_WIDTH-1:0]   op_a;
  logic [OP_WIDTH-1:0]   op_b;
  logic                  op_sub;
  logic                  op_ci;
  logic [OP_WIDTH-1:0]   sum_next;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req     (req_valid),
    .ptr     (rr_ptr),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .any     (gnt_any)
  );

  // Grant is offered only while idle and out of reset, so accept == valid & ready.
  assign req_ready = (state == IDLE && ireset) ? gnt : '0;

  always_comb begin
    add_a  = '0;
    add_b  = '0;
    add_ci = 1'b0;
    if (state == RUN) begin
      add_a  = op_a[beat*ADDER_W +: ADDER_W];
      add_b  = op_sub ? ~op_b[beat*ADDER_W +: ADDER_W] : op_b[beat*ADDER_W +: ADDER_W];
      add_ci = (beat == '0) ? op_ci : carry;
    end
  end

  // Full result as it will look once this beat's slice lands; feeds the zero flag.
  always_comb begin
    sum_next = rsp_sum;
    sum_next[beat*ADDER_W +: ADDER_W] = add_s;
  end

  always_ff @(posedge cp2 or negedge ireset) begin
    if (!ireset) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      beat      <= '0;
      carry     <= 1'b0;
      op_a      <= '0;
      op_b      <= '0;
      op_sub    <= 1'b0;
      op_ci     <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_sum   <= '0;
      rsp_co    <= 1'b0;
      rsp_z     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (gnt_any) begin
            op_a   <= req_a[gnt_idx*OP_WIDTH +: OP_WIDTH];
            op_b   <= req_b[gnt_idx*OP_WIDTH +: OP_WIDTH];
            op_sub <= req_sub[gnt_idx];
            op_ci  <= req_ci[gnt_idx];
            rsp_id <= gnt_idx;
            beat   <= '0;
            rr_ptr <= (gnt_idx == LAST_ID) ? '0 : gnt_idx + 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          rsp_sum <= sum_next;
          carry   <= add_co;
          if (beat == LAST_BEAT) begin
            rsp_co    <= add_co;
            rsp_z     <= (sum_next == '0);
            rsp_valid <= 1'b1;
            state     <= DONE;
          end else begin
            beat <= beat + 1'b1;
          end
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_wide_adder_sched.sv
// Randomised bench for wide_adder_sched against a cycle-level behavioural model.
module tb_wide_adder_sched;

  localparam int NUM_REQ  = 2;
  localparam int OP_WIDTH = 32;
  localparam int NBEAT    = OP_WIDTH / 16;

  logic                        cp2;
  logic                        ireset;
  logic [NUM_REQ-1:0]          req_valid;
  logic [NUM_REQ-1:0]          req_ready;
  logic [NUM_REQ*OP_WIDTH-1:0] req_a;
  logic [NUM_REQ*OP_WIDTH-1:0] req_b;
  logic [NUM_REQ-1:0]          req_sub;
  logic [NUM_REQ-1:0]          req_ci;
  logic                        rsp_valid;
  logic                        rsp_ready;
  logic [1:0]                  rsp_id;
  logic [OP_WIDTH-1:0]         rsp_sum;
  logic                        rsp_co;
  logic                        rsp_z;
  logic [15:0]                 add_a;
  logic [15:0]                 add_b;
  logic                        add_ci;
  logic [15:0]                 add_s;
  logic                        add_co;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  wide_adder_sched #(.NUM_REQ(NUM_REQ), .OP_WIDTH(OP_WIDTH)) dut (
    .cp2       (cp2),
    .ireset    (ireset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_sub   (req_sub),
    .req_ci    (req_ci),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_sum   (rsp_sum),
    .rsp_co    (rsp_co),
    .rsp_z     (rsp_z),
    .add_a     (add_a),
    .add_b     (add_b),
    .add_ci    (add_ci),
    .add_s     (add_s),
    .add_co    (add_co)
  );

  // The shared ALU adder that the parent would normally provide.
  assign {add_co, add_s} = 17'(add_a) + 17'(add_b) + 17'(add_ci);

  initial cp2 = 1'b0;
  always #5 cp2 = ~cp2;
  always @(posedge cp2) cyc++;

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Behavioural model: at most one operation in flight; response due NBEAT+1 cycles after accept.
  int          m_ptr = 0;
  bit          m_busy = 0;
  int          m_wait = 0;
  int          m_id = 0;
  int          m_rsp_count = 0;
  logic [31:0] m_a, m_b;
  bit          m_sub, m_ci;
  logic [63:0] e_bop, e_full, lo_mask, lo_sum;
  logic [NUM_REQ-1:0] exp_gnt;
  int          g, k;
  bit          e_cin;

  always @(negedge cp2) begin
    if (!ireset) begin
      checkOutput("rst_req_ready", 64'(req_ready), 64'd0);
      checkOutput("rst_rsp_valid", 64'(rsp_valid), 64'd0);
      checkOutput("rst_rsp_id",    64'(rsp_id), 64'd0);
      checkOutput("rst_rsp_sum",   64'(rsp_sum), 64'd0);
      checkOutput("rst_rsp_co_z",  64'({rsp_co, rsp_z}), 64'd0);
      checkOutput("rst_add",       64'({add_a, add_b, add_ci}), 64'd0);
      m_ptr  = 0;
      m_busy = 0;
      m_wait = 0;
    end else begin
      if (m_busy && m_wait > 0) m_wait--;
      exp_gnt = '0;
      g = -1;
      if (!m_busy) begin
        for (int off = 0; off < NUM_REQ; off++) begin
          if (g < 0 && req_valid[(m_ptr + off) % NUM_REQ]) g = (m_ptr + off) % NUM_REQ;
        end
        if (g >= 0) exp_gnt[g] = 1'b1;
      end
      checkOutput("req_ready", 64'(req_ready), 64'(exp_gnt));
      checkOutput("rsp_valid", 64'(rsp_valid), 64'(m_busy && m_wait == 0));

      e_bop  = {32'd0, m_sub ? ~m_b : m_b};
      e_full = {32'd0, m_a} + e_bop + 64'(m_ci);
      if (m_busy && m_wait == 0) begin
        checkOutput("rsp_id",  64'(rsp_id), 64'(m_id));
        checkOutput("rsp_sum", 64'(rsp_sum), {32'd0, e_full[31:0]});
        checkOutput("rsp_co",  64'(rsp_co), 64'(e_full[32]));
        checkOutput("rsp_z",   64'(rsp_z), 64'(e_full[31:0] == 32'd0));
      end

      if (m_busy && m_wait > 0) begin
        k = NBEAT - m_wait;
        if (k == 0) begin
          e_cin = m_ci;
        end else begin
          lo_mask = (64'd1 << (16 * k)) - 64'd1;
          lo_sum  = ({32'd0, m_a} & lo_mask) + (e_bop & lo_mask) + 64'(m_ci);
          e_cin   = lo_sum[16*k];
        end
        checkOutput("add_a",  64'(add_a), ({32'd0, m_a} >> (16 * k)) & 64'hFFFF);
        checkOutput("add_b",  64'(add_b), (e_bop >> (16 * k)) & 64'hFFFF);
        checkOutput("add_ci", 64'(add_ci), 64'(e_cin));
      end else begin
        checkOutput("add_idle", 64'({add_a, add_b, add_ci}), 64'd0);
      end

      if (g >= 0) begin
        m_a    = req_a[g*OP_WIDTH +: OP_WIDTH];
        m_b    = req_b[g*OP_WIDTH +: OP_WIDTH];
        m_sub  = req_sub[g];
        m_ci   = req_ci[g];
        m_id   = g;
        m_busy = 1;
        m_wait = NBEAT + 1;
        m_ptr  = (g + 1) % NUM_REQ;
      end else if (m_busy && m_wait == 0 && rsp_ready) begin
        m_busy = 0;
        m_rsp_count++;
      end
    end
  end

  task automatic applyStimulus(input int id, input logic [31:0] a, input logic [31:0] b,
                               input bit sub, input bit ci);
    req_a[id*OP_WIDTH +: OP_WIDTH] = a;
    req_b[id*OP_WIDTH +: OP_WIDTH] = b;
    req_sub[id] = sub;
    req_ci[id]  = ci;
  endtask

  task automatic doReset();
    @(posedge cp2);
    #1 ireset = 1'b0;
    req_valid = '0;
    rsp_ready = 1'b0;
    repeat (2) @(posedge cp2);
    #1 ireset = 1'b1;
  endtask

  task automatic waitAccept(input int id, output bit ok);
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge cp2);
      if (req_ready[id]) ok = 1;
    end
    if (!ok) checkOutput("accept_timeout", 64'd0, 64'd1);
  endtask

  task automatic waitRsp(output bit ok);
    ok = 0;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge cp2);
      if (rsp_valid) ok = 1;
    end
    if (!ok) checkOutput("rsp_timeout", 64'd0, 64'd1);
  endtask

  // One operation on requester id with hand-computed expected results and latency.
  task automatic runOne(input int id, input logic [31:0] a, input logic [31:0] b, input bit sub,
                        input bit ci, input logic [31:0] esum, input bit eco, input bit ez);
    bit ok;
    int t0;
    @(posedge cp2);
    #1 applyStimulus(id, a, b, sub, ci);
    req_valid[id] = 1'b1;
    waitAccept(id, ok);
    t0 = cyc;
    @(posedge cp2);
    #1 req_valid[id] = 1'b0;
    applyStimulus(id, $urandom, $urandom, 1'($urandom), 1'($urandom));
    waitRsp(ok);
    checkOutput("lit_latency", 64'(cyc - t0), 64'd3);
    checkOutput("lit_sum", 64'(rsp_sum), 64'(esum));
    checkOutput("lit_co",  64'(rsp_co), 64'(eco));
    checkOutput("lit_z",   64'(rsp_z), 64'(ez));
    checkOutput("lit_id",  64'(rsp_id), 64'(id));
    @(posedge cp2);
    #1 rsp_ready = 1'b1;
    @(posedge cp2);
    #1 rsp_ready = 1'b0;
  endtask

  initial begin
    bit ok;
    int exp_ids[4];
    exp_ids = '{0, 1, 0, 1};
    ireset    = 1'b0;
    req_valid = '0;
    req_a     = '0;
    req_b     = '0;
    req_sub   = '0;
    req_ci    = '0;
    rsp_ready = 1'b0;
    repeat (3) @(posedge cp2);
    #1 ireset = 1'b1;

    runOne(0, 32'h0001_FFFF, 32'h0000_0001, 0, 0, 32'h0002_0000, 0, 0);
    runOne(0, 32'h0000_0000, 32'h0000_0001, 1, 1, 32'hFFFF_FFFF, 0, 0);
    runOne(0, 32'hFFFF_FFFF, 32'h0000_0001, 0, 0, 32'h0000_0000, 1, 1);

    // Arbitration from reset: 0 then 1; a lone req0 then leaves the pointer at 1.
    doReset();
    @(posedge cp2);
    #1 applyStimulus(0, 32'h0000_0010, 32'h0000_0020, 0, 0);
    applyStimulus(1, 32'h0300_0000, 32'h0000_0004, 1, 1);
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      waitRsp(ok);
      checkOutput("arb_id", 64'(rsp_id), 64'(exp_ids[n]));
      @(posedge cp2);
      #1 req_valid = (n == 1) ? 2'b01 : 2'b11;
    end
    req_valid = '0;
    repeat (6) @(posedge cp2);

    // Backpressure: response held for 5 cycles with req1 waiting.
    #1 rsp_ready = 1'b0;
    applyStimulus(0, 32'h1234_5678, 32'h1111_1111, 0, 0);
    applyStimulus(1, 32'h0000_8000, 32'h0000_8000, 0, 1);
    req_valid = 2'b01;
    waitAccept(0, ok);
    @(posedge cp2);
    #1 req_valid = 2'b10;
    waitRsp(ok);
    repeat (5) begin
      @(negedge cp2);
      checkOutput("bp_valid", 64'(rsp_valid), 64'd1);
      checkOutput("bp_sum",   64'(rsp_sum), 64'h2345_6789);
      checkOutput("bp_ready", 64'(req_ready), 64'd0);
    end
    @(posedge cp2);
    #1 rsp_ready = 1'b1;
    @(posedge cp2);
    @(negedge cp2);
    checkOutput("bp_release_valid", 64'(rsp_valid), 64'd0);
    checkOutput("bp_release_ready", 64'(req_ready), 64'b10);
    @(posedge cp2);
    #1 req_valid = '0;
    repeat (6) @(posedge cp2);

    // Reset during beat 0 of a req0 operation.
    #1 rsp_ready = 1'b0;
    applyStimulus(0, 32'hABCD_1234, 32'h5555_AAAA, 1, 1);
    req_valid = 2'b01;
    waitAccept(0, ok);
    @(posedge cp2);
    #2 ireset = 1'b0;
    req_valid = '0;
    #1 checkOutput("mid_rst_outputs",
                   64'({req_ready, rsp_valid, rsp_id, rsp_co, rsp_z, add_ci}), 64'd0);
    checkOutput("mid_rst_add", 64'({add_a, add_b}), 64'd0);
    checkOutput("mid_rst_sum", 64'(rsp_sum), 64'd0);
    repeat (2) @(posedge cp2);
    #1 ireset = 1'b1;
    repeat (6) begin
      @(negedge cp2);
      checkOutput("no_rsp_after_rst", 64'(rsp_valid), 64'd0);
    end
    @(posedge cp2);
    #1 req_valid = 2'b11;
    rsp_ready = 1'b1;
    waitRsp(ok);
    checkOutput("ptr_after_rst", 64'(rsp_id), 64'd0);
    @(posedge cp2);
    #1 req_valid = '0;
    repeat (4) @(posedge cp2);

    // Random traffic, with occasional all-ones / zero operands to exercise carries.
    for (int i = 0; i < 600; i++) begin
      @(posedge cp2);
      #1;
      for (int r = 0; r < NUM_REQ; r++) begin
        applyStimulus(r,
          ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom,
          ($urandom_range(0, 3) == 0) ? 32'h0000_0000 : (($urandom_range(0, 2) == 0) ? 32'h1 : $urandom),
          1'($urandom), 1'($urandom));
      end
      req_valid = NUM_REQ'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge cp2);
    #1 req_valid = '0;
    rsp_ready = 1'b1;
    repeat (10) @(posedge cp2);
    checkOutput("random_progress", 64'(m_rsp_count > 40), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "[TB] watchdog");
  end

endmodule
